pll_dri_master: RTL



---
 rtl/pll_dri_master_if.sv | 38 +++
 rtl/pll_dri_master.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pll_dri_master_if.sv
//------------------------------------------------------------------------------
// Module      : pll_dri_master_if
// Description : Request/response bus from the soft CPU plus the PLL DRI port
//               and lock input, bundled for the DRI master.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pll_dri_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [10:0] dri_ctrl;
    logic [32:0] dri_wdata;
    logic [32:0] dri_rdata;
    logic        dri_arst_n;
    logic        lock;

    // DRI master side
    modport master (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, dri_rdata, lock,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, dri_ctrl, dri_wdata, dri_arst_n
    );

    // CPU bus / PLL side
    modport slave (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, dri_rdata, lock,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, dri_ctrl, dri_wdata, dri_arst_n
    );
endinterface

`default_nettype wire

// File: rtl/pll_dri_master.sv
//------------------------------------------------------------------------------
// Module      : pll_dri_master
// Description : Fabric-side initiator for the PLL Dynamic Reconfiguration
//               Interface. One framed DRI transaction per CPU request, done
//               timeout, optional wait for PLL re-lock after writes.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pll_dri_master #(
    parameter int TIMEOUT    = 256,   // 2..65535
    parameter bit WAIT_LOCK  = 1'b1,
    parameter int LOCK_BLANK = 32     // >= 1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    pll_dri_master_if.master  bus
);

    // One extra counter bit so LOCK_BLANK+TIMEOUT-1 fits in the lock wait.
    localparam int CNT_W = 17;
    localparam logic [CNT_W-1:0] c_wait_last  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_blank      = CNT_W'(LOCK_BLANK);
    localparam logic [CNT_W-1:0] c_lock_last  = CNT_W'(LOCK_BLANK + TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_LOCKW = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t             r_state;
    logic [1:0]         r_arst_sync;
    logic [1:0]         r_lock_sync;
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic [31:0]        r_rsp_rdata;
    logic [1:0]         r_rsp_err;
    logic               r_strobe;
    logic               r_write;
    logic [7:0]         r_addr;
    logic [31:0]        r_wdata;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_done;
    logic               w_lock;

    assign w_done = bus.dri_rdata[32];
    assign w_lock = r_lock_sync[1];

    // DRI reset: asserts with rst_n, releases on the second clk edge after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_arst_sync <= 2'b00;
        else        r_arst_sync <= {r_arst_sync[0], 1'b1};
    end

    // Bring the asynchronous PLL lock into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_lock_sync <= 2'b00;
        else        r_lock_sync <= {r_lock_sync[0], bus.lock};
    end

    // Transaction sequencer with all bus and DRI outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 2'd0;
            r_strobe    <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= 8'd0;
            r_wdata     <= 32'd0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Ready tracks the DRI reset release so it rises with it.
                    r_req_ready <= r_arst_sync[0];
                    if (bus.req_valid && r_req_ready) begin
                        r_write     <= bus.req_write;
                        r_addr      <= bus.req_addr;
                        r_wdata     <= bus.req_wdata;
                        r_strobe    <= 1'b1;
                        r_req_ready <= 1'b0;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_strobe <= 1'b0;
                    r_cnt    <= '0;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // Done takes priority over a coincident timeout.
                    if (w_done) begin
                        if (!r_write) begin
                            r_rsp_rdata <= bus.dri_rdata[31:0];
                            r_rsp_err   <= 2'd0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else if (WAIT_LOCK) begin
                            r_cnt   <= '0;
                            r_state <= S_LOCKW;
                        end else begin
                            r_rsp_rdata <= 32'd0;
                            r_rsp_err   <= 2'd0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end else if (r_cnt == c_wait_last) begin
                        r_rsp_rdata <= 32'd0;
                        r_rsp_err   <= 2'd1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_LOCKW: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // Lock is blanked right after the write while the PLL drops it.
                    if ((r_cnt >= c_blank) && w_lock) begin
                        r_rsp_rdata <= 32'd0;
                        r_rsp_err   <= 2'd0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_cnt == c_lock_last) begin
                        r_rsp_rdata <= 32'd0;
                        r_rsp_err   <= 2'd2;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= 32'd0;
                        r_rsp_err   <= 2'd0;
                        r_req_ready <= r_arst_sync[0];
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_rdata  = r_rsp_rdata;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.dri_ctrl   = {r_strobe, r_write, r_addr, 1'b0};
    assign bus.dri_wdata  = {1'b0, r_wdata};
    assign bus.dri_arst_n = r_arst_sync[1];

endmodule

`default_nettype wire
